// File: rtl/ttl_decoder_scan_sequencer_if.sv
// Control/status bundle between a scan controller and ttl_decoder_scan_sequencer.
// Skip_mask exists only when SCAN_SKIP_MASK_EN is defined.
interface ttl_decoder_scan_sequencer_if #(
  parameter int WIDTH_OUT = 8,
  parameter int WIDTH_IN  = $clog2(WIDTH_OUT)
);
  logic                 Run;
  logic                 Hold;
`ifdef SCAN_SKIP_MASK_EN
  logic [WIDTH_OUT-1:0] Skip_mask;
`endif
  logic [WIDTH_IN-1:0]  A;
  logic                 Enable1_bar;
  logic                 Enable2_bar;
  logic                 Enable3;
  logic                 Frame_start;
  logic                 Done;
  logic                 Busy;

`ifdef SCAN_SKIP_MASK_EN
  modport master (output Run, Hold, Skip_mask,
                  input  A, Enable1_bar, Enable2_bar, Enable3, Frame_start, Done, Busy);
  modport slave  (input  Run, Hold, Skip_mask,
                  output A, Enable1_bar, Enable2_bar, Enable3, Frame_start, Done, Busy);
`else
  modport master (output Run, Hold,
                  input  A, Enable1_bar, Enable2_bar, Enable3, Frame_start, Done, Busy);
  modport slave  (input  Run, Hold,
                  output A, Enable1_bar, Enable2_bar, Enable3, Frame_start, Done, Busy);
`endif
endinterface

// File: rtl/ttl_decoder_scan_sequencer.sv
// Line-scan sequencer driving address/enables of a 3-to-8 inverted-output decoder.
// Optional skip mask enabled with `define SCAN_SKIP_MASK_EN. DELAY_RISE/DELAY_FALL are zero-delay here.
module ttl_decoder_scan_sequencer #(
  parameter int WIDTH_OUT    = 8,
  parameter int WIDTH_IN     = $clog2(WIDTH_OUT),
  parameter int DWELL_CYCLES = 4,
  parameter int BLANK_CYCLES = 1,
  parameter int DELAY_RISE   = 0,
  parameter int DELAY_FALL   = 0
) (
  input  logic                         Clk,
  input  logic                         Clear_bar,
  ttl_decoder_scan_sequencer_if.slave  bus
);
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_DWELL = 2'd2;
  localparam logic [1:0] S_ENTRY = (BLANK_CYCLES == 0) ? S_DWELL : S_BLANK;

  if (DWELL_CYCLES < 1 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_cfg
    $error("ttl_decoder_scan_sequencer: DWELL_CYCLES must be >= 1 and delays non-negative");
  end

  logic [1:0]          state_q, state_d;
  logic [WIDTH_IN-1:0] line_q, line_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                en_q, fs_q, fs_d, done_q, done_d, busy_q;
  logic [WIDTH_OUT-1:0] mask;
  logic [WIDTH_IN:0]   first_pick, next_pick;

`ifdef SCAN_SKIP_MASK_EN
  assign mask = bus.Skip_mask;
`else
  assign mask = '0;
`endif

  // Returns {found, index} of the lowest unmasked line at or above 'from'.
  function automatic logic [WIDTH_IN:0] pick_line(input logic [WIDTH_OUT-1:0] m,
                                                  input int unsigned from);
    pick_line = '0;
    for (int unsigned i = WIDTH_OUT; i > 0; i--) begin
      if ((i - 1) >= from && !m[i-1]) pick_line = {1'b1, WIDTH_IN'(i - 1)};
    end
  endfunction

  assign first_pick = pick_line(mask, 0);
  assign next_pick  = pick_line(mask, 32'(line_q) + 32'd1);

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    fs_d    = 1'b0;
    done_d  = 1'b0;
    if (!bus.Hold) begin
      case (state_q)
        S_IDLE: begin
          if (bus.Run && first_pick[WIDTH_IN]) begin
            line_d  = first_pick[WIDTH_IN-1:0];
            cnt_d   = '0;
            fs_d    = 1'b1;
            state_d = S_ENTRY;
          end
        end
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d   = '0;
            state_d = S_DWELL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DWELL: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d = '0;
            if (next_pick[WIDTH_IN]) begin
              line_d  = next_pick[WIDTH_IN-1:0];
              state_d = S_ENTRY;
            end else if (bus.Run && first_pick[WIDTH_IN]) begin
              // Wrap goes straight into the next frame's first line: no idle gap.
              line_d  = first_pick[WIDTH_IN-1:0];
              fs_d    = 1'b1;
              state_d = S_ENTRY;
            end else begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      fs_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
      en_q    <= (state_d == S_DWELL);
      fs_q    <= fs_d;
      done_q  <= done_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign bus.A           = line_q;
  assign bus.Enable1_bar = ~en_q;
  assign bus.Enable2_bar = ~en_q;
  assign bus.Enable3     = en_q;
  assign bus.Frame_start = fs_q;
  assign bus.Done        = done_q;
  assign bus.Busy        = busy_q;
endmodule
